// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller.
// Decoded instructions are queued in a small FIFO and issued one per cycle onto
// registered ex_* outputs. Issue stalls while a memory read is outstanding, and a
// one-cycle bubble is inserted when the first instruction after a load reads the
// loaded register.
module ex_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     flush,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    input  logic [6:0]               dec_control,
    input  logic [31:0]              dec_src1,
    input  logic [31:0]              dec_src2,
    input  logic [31:0]              dec_imm,
    input  logic [4:0]               dec_rs1,
    input  logic [4:0]               dec_rs2,
    input  logic [4:0]               dec_rd,
    input  logic                     mem_rd_done,
    output logic                     enable_ex,
    output logic [6:0]               ex_control,
    output logic [31:0]              ex_src1,
    output logic [31:0]              ex_src2,
    output logic [31:0]              ex_imm,
    output logic                     mem_rd_pending,
    output logic                     mem_timeout,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        MEM_WAIT = 2'd2,
        BUBBLE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [6:0]  control;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } entry_t;

    entry_t          fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   occ_reg;
    logic [CW-1:0]   occ_next;
    logic [TW-1:0]   wait_cnt_reg;
    logic            hazard_arm_reg;
    logic [4:0]      load_rd_reg;
    logic            mem_timeout_reg;
    logic            enable_ex_reg;
    logic [6:0]      ex_control_reg;
    logic [31:0]     ex_src1_reg;
    logic [31:0]     ex_src2_reg;
    logic [31:0]     ex_imm_reg;
    state_t          state_reg;
    state_t          state_next;

    logic            empty;
    logic            full;
    logic            push;
    logic            issue;
    logic            bubble_go;
    logic            hazard;
    logic            head_is_read;
    logic            last_pop;
    logic            wait_done;
    logic            wait_expire;
    entry_t          head;

    // State register; an asynchronous reset abandons any outstanding read.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Control decode: FIFO status, hazard detection and the issue decision.
    // IDLE may issue directly so a push at edge N can appear on ex_* at N+1;
    // BUBBLE always issues since the hazard it waited out is gone.
    always_comb begin
        empty          = (occ_reg == '0);
        full           = (occ_reg == CW'(DEPTH));
        dec_ready      = !full;
        push           = dec_valid && !full;
        head           = fifo_mem[rd_ptr_reg];
        head_is_read   = head.control[3] && (head.control[2:0] == 3'b101);
        hazard         = hazard_arm_reg && (load_rd_reg != 5'd0) &&
                         ((head.rs1 == load_rd_reg) || (head.rs2 == load_rd_reg));
        issue          = 1'b0;
        bubble_go      = 1'b0;
        if (!empty) begin
            if (state_reg == BUBBLE) begin
                issue = 1'b1;
            end else if (state_reg == IDLE || state_reg == ISSUE) begin
                issue     = !hazard;
                bubble_go = hazard;
            end
        end
        last_pop       = issue && (occ_reg == CW'(1)) && !push;
        wait_done      = (state_reg == MEM_WAIT) && mem_rd_done;
        wait_expire    = (state_reg == MEM_WAIT) && !mem_rd_done &&
                         (wait_cnt_reg == TW'(MEM_TIMEOUT - 1));
        mem_rd_pending = (state_reg == MEM_WAIT);
        occ_next       = occ_reg + CW'(push) - CW'(issue);
    end

    // Next-state selection; flush overrides every other transition.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, ISSUE, BUBBLE: begin
                    if (issue) begin
                        if (head_is_read)
                            state_next = MEM_WAIT;
                        else if (last_pop)
                            state_next = IDLE;
                        else
                            state_next = ISSUE;
                    end else if (bubble_go) begin
                        state_next = BUBBLE;
                    end else begin
                        state_next = IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (wait_done || wait_expire)
                        state_next = empty ? IDLE : ISSUE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FIFO storage; entries are not reset because the pointers define validity.
    always_ff @(posedge CLOCK) begin
        if (RESET && push && !flush) begin
            fifo_mem[wr_ptr_reg] <= '{control: dec_control, src1: dec_src1,
                                      src2: dec_src2, imm: dec_imm,
                                      rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd};
        end
    end

    // Pointers, occupancy, wait counter, hazard tracking and the issued bundle.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            wait_cnt_reg    <= '0;
            hazard_arm_reg  <= 1'b0;
            load_rd_reg     <= 5'd0;
            mem_timeout_reg <= 1'b0;
            enable_ex_reg   <= 1'b0;
            ex_control_reg  <= 7'd0;
            ex_src1_reg     <= 32'd0;
            ex_src2_reg     <= 32'd0;
            ex_imm_reg      <= 32'd0;
        end else if (flush) begin
            // ex_* and the sticky timeout flag deliberately survive a flush.
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            occ_reg         <= '0;
            wait_cnt_reg    <= '0;
            hazard_arm_reg  <= 1'b0;
            enable_ex_reg   <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (issue)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            occ_reg       <= occ_next;
            enable_ex_reg <= issue;
            if (issue) begin
                ex_control_reg <= head.control;
                ex_src1_reg    <= head.src1;
                ex_src2_reg    <= head.src2;
                ex_imm_reg     <= head.imm;
            end
            if (issue && head_is_read)
                load_rd_reg <= head.rd;
            if (state_reg == MEM_WAIT && !wait_done && !wait_expire)
                wait_cnt_reg <= wait_cnt_reg + TW'(1);
            else
                wait_cnt_reg <= '0;
            // Arm only once the read data is back; a timeout leaves nothing to guard.
            if (wait_done)
                hazard_arm_reg <= 1'b1;
            else if (wait_expire || issue || bubble_go)
                hazard_arm_reg <= 1'b0;
            if (wait_expire)
                mem_timeout_reg <= 1'b1;
        end
    end

    assign enable_ex   = enable_ex_reg;
    assign ex_control  = ex_control_reg;
    assign ex_src1     = ex_src1_reg;
    assign ex_src2     = ex_src2_reg;
    assign ex_imm      = ex_imm_reg;
    assign mem_timeout = mem_timeout_reg;
    assign occupancy   = occ_reg;

endmodule
